// File: rtl/prf_wb_arbiter.sv
// prf_wb_arbiter: round-robin arbiter for the PRF write port with a registered write/CDB stage
module prf_wb_arbiter #(
    parameter int               NUM_REQ  = 4,
    parameter int               DATA_W   = 64,
    parameter int               IDX_W    = 7,
    parameter logic [IDX_W-1:0] ZERO_IDX = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*IDX_W-1:0]  req_idx_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      wr_en_o,
    output logic [IDX_W-1:0]          wr_idx_o,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic                      cdb_valid_o,
    output logic [IDX_W-1:0]          cdb_tag_o,
    output logic [7:0]                busy_cnt_o
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  win;
    logic              any;
    logic              multi;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_data;
    int                j;

    // Scan from the pointer upward with wrap; scanning offsets high-to-low lets the nearest requester win
    always_comb begin
        win = ptr_r;
        any = 1'b0;
        j   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr_r) + i;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            if (req_i[j]) begin
                win = PTR_W'(j);
                any = 1'b1;
            end
        end
        any = any & ~flush_i;
    end

    assign gnt_o       = (any && rst_n) ? NUM_REQ'(1) << win : '0;
    assign sel_idx     = req_idx_i[int'(win)*IDX_W +: IDX_W];
    assign sel_data    = req_data_i[int'(win)*DATA_W +: DATA_W];
    assign multi       = $countones(req_i) > 1;
    assign cdb_valid_o = wr_en_o;
    assign cdb_tag_o   = wr_idx_o;

    // Register the winner for the PRF port/CDB, advance the pointer past it, track contention length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r      <= '0;
            wr_en_o    <= 1'b0;
            wr_idx_o   <= '0;
            wr_data_o  <= '0;
            busy_cnt_o <= '0;
        end else begin
            wr_en_o <= any && (sel_idx != ZERO_IDX);
            if (any) begin
                wr_idx_o  <= sel_idx;
                wr_data_o <= sel_data;
                ptr_r     <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            if (!multi)
                busy_cnt_o <= '0;
            else if (!flush_i && busy_cnt_o != 8'hFF)
                busy_cnt_o <= busy_cnt_o + 8'd1;
        end
    end
endmodule
